// File: rtl/seven_seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
package seven_seg_pkg;

  localparam int SEG_W = 8;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // Active-high ABCDEFG patterns indexed by hex value.
  localparam logic [6:0] HEX_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef struct packed {
    logic       dp;
    logic [3:0] val;
  } digit_t;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display register / display pin bundle for seven_seg_scan.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 4
);
  logic [5*NUM_DIGITS-1:0] digits_in;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   anode_sel;
  logic [7:0]              segments_out;
  logic                    frame_tick;

  modport master (
    output digits_in, brightness,
    input  anode_sel, segments_out, frame_tick
  );

  modport slave (
    input  digits_in, brightness,
    output anode_sel, segments_out, frame_tick
  );
endinterface

// File: rtl/seven_seg_scan_decode.sv
// Combinational hex + DP to active-low segment decoder with blank override.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  digit_t           digit,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) seg = ~{HEX_TABLE[digit.val], digit.dp};
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed common-anode seven-segment scanner with PWM and frame-synchronous capture.
// Define SEVEN_SEG_LZB_EN to enable leading-zero blanking at capture.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 12500,
  parameter int BRIGHT_W   = 4
) (
  input logic           mclk,
  input logic           rst_N,
  seven_seg_scan_if.slave bus
);

  localparam int PHASES = 2 ** BRIGHT_W;
  localparam int PRE_N  = CLK_DIV / PHASES;
  localparam int PRE_W  = (PRE_N > 1) ? $clog2(PRE_N) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  logic [PRE_W-1:0]    pre;
  logic [BRIGHT_W-1:0] phase;
  logic [IDX_W-1:0]    idx;
  logic                pre_tc, phase_tc, idx_tc, frame_start;

  digit_t              shadow [NUM_DIGITS];
  logic [BRIGHT_W-1:0] bright_q;
  logic [BRIGHT_W-1:0] bright_eff;
  digit_t              cur_digit;
  logic                cur_blank;
  logic [SEG_W-1:0]    seg_dec;

  assign pre_tc      = (pre == PRE_W'(PRE_N - 1));
  assign phase_tc    = (phase == '1);
  assign idx_tc      = (idx == IDX_W'(NUM_DIGITS - 1));
  // All-zero counters mark both the post-reset cycle and every wrap of idx.
  assign frame_start = (pre == '0) && (phase == '0) && (idx == '0);

  always_ff @(posedge mclk or negedge rst_N) begin
    if (!rst_N) begin
      pre   <= '0;
      phase <= '0;
      idx   <= '0;
    end else begin
      pre <= pre_tc ? '0 : pre + 1'b1;
      if (pre_tc) begin
        phase <= phase + 1'b1;
        if (phase_tc) idx <= idx_tc ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge mclk or negedge rst_N) begin
    if (!rst_N) begin
      bright_q <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) shadow[k] <= '0;
    end else if (frame_start) begin
      bright_q <= bus.brightness;
      for (int k = 0; k < NUM_DIGITS; k++) shadow[k] <= digit_t'(bus.digits_in[5*k +: 5]);
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  logic [NUM_DIGITS-1:0] blank_next, blank_q;
  logic                  lz_run;

  always_comb begin
    blank_next = '0;
    lz_run     = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run        = lz_run && (bus.digits_in[5*k +: 5] == 5'd0);
      blank_next[k] = lz_run;
    end
  end

  always_ff @(posedge mclk or negedge rst_N) begin
    if (!rst_N)           blank_q <= '0;
    else if (frame_start) blank_q <= blank_next;
  end

  assign cur_blank = blank_q[idx];
`else
  assign cur_blank = 1'b0;
`endif

  // In the capture cycle idx is 0, so the live inputs stand in for the shadow
  // being written; this keeps the first output cycle of a frame on new data.
  assign cur_digit  = frame_start ? digit_t'(bus.digits_in[4:0]) : shadow[idx];
  assign bright_eff = frame_start ? bus.brightness : bright_q;

  seven_seg_decode u_decode (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (seg_dec)
  );

  always_ff @(posedge mclk or negedge rst_N) begin
    if (!rst_N) begin
      bus.anode_sel    <= '1;
      bus.segments_out <= SEG_BLANK;
      bus.frame_tick   <= 1'b0;
    end else begin
      bus.frame_tick <= frame_start;
      if (phase < bright_eff) begin
        bus.anode_sel    <= ~(NUM_DIGITS'(1) << idx);
        bus.segments_out <= seg_dec;
      end else begin
        bus.anode_sel    <= '1;
        bus.segments_out <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: time-based reference model plus directed scenarios.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int CD = 64;
  localparam int BW = 2;
  localparam int FRAME = ND * CD;
  localparam int SLOT_PHASE = CD / (2 ** BW);

  logic mclk = 1'b0;
  logic rst_N = 1'b0;
  always #5 mclk = ~mclk;

  seven_seg_scan_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

  seven_seg_scan #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BRIGHT_W(BW)) dut (
    .mclk  (mclk),
    .rst_N (rst_N),
    .bus   (bus)
  );

  logic [6:0] hex_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int tests = 0;
  int fails = 0;

  // Reference model: edges since reset release and the frame-start captures.
  int          ecnt;
  logic [19:0] cap_d;
  logic [1:0]  cap_b;
  logic [3:0]  cap_blank;

  function automatic logic [3:0] lzb(input logic [19:0] d);
    lzb = 4'b0000;
`ifdef SEVEN_SEG_LZB_EN
    begin
      logic run;
      run = 1'b1;
      for (int k = 3; k >= 1; k--) begin
        run    = run && (d[5*k +: 5] == 5'd0);
        lzb[k] = run;
      end
    end
`endif
  endfunction

  always @(posedge mclk or negedge rst_N) begin
    if (!rst_N) begin
      ecnt <= 0;
    end else begin
      if (ecnt % FRAME == 0) begin
        cap_d     <= bus.digits_in;
        cap_b     <= bus.brightness;
        cap_blank <= lzb(bus.digits_in);
      end
      ecnt <= ecnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    int p, slot, ph;
    logic lit;
    logic [3:0] exp_an;
    logic [7:0] exp_sg;
    logic [4:0] dig;
    forever begin
      @(negedge mclk);
      if (!rst_N || ecnt == 0) begin
        check("model_rst_anode", {28'd0, bus.anode_sel}, 32'hF);
        check("model_rst_seg", {24'd0, bus.segments_out}, 32'hFF);
        check("model_rst_tick", {31'd0, bus.frame_tick}, 32'd0);
      end else begin
        p    = (ecnt - 1) % FRAME;
        slot = p / CD;
        ph   = (p % CD) / SLOT_PHASE;
        lit  = (ph < int'(cap_b));
        dig  = cap_d[5*slot +: 5];
        exp_an = 4'b0001 << slot;
        exp_an = lit ? ~exp_an : 4'hF;
        exp_sg = (lit && !cap_blank[slot]) ? ~{hex_tab[dig[3:0]], dig[4]} : 8'hFF;
        check("model_anode", {28'd0, bus.anode_sel}, {28'd0, exp_an});
        check("model_seg", {24'd0, bus.segments_out}, {24'd0, exp_sg});
        check("model_tick", {31'd0, bus.frame_tick}, {31'd0, p == 0});
      end
    end
  endtask

  int         lo_cnt [4];
  int         dark_cnt;
  int         dark_seg_bad;
  logic [7:0] seg_seen [4];

  // Starts on the frame_tick negedge and ends on the last negedge of that frame.
  task automatic measure();
    logic [3:0] m;
    dark_cnt = 0;
    dark_seg_bad = 0;
    for (int k = 0; k < 4; k++) begin
      lo_cnt[k] = 0;
      seg_seen[k] = 8'h00;
    end
    for (int i = 0; i < FRAME; i++) begin
      for (int k = 0; k < 4; k++) begin
        m = 4'b0001 << k;
        m = ~m;
        if (bus.anode_sel == m) begin
          lo_cnt[k]++;
          seg_seen[k] = bus.segments_out;
        end
      end
      if (bus.anode_sel == 4'hF) begin
        dark_cnt++;
        if (bus.segments_out != 8'hFF) dark_seg_bad++;
      end
      if (i < FRAME - 1) @(negedge mclk);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge mclk);
    while (!bus.frame_tick && n < 2 * FRAME) begin
      @(negedge mclk);
      n++;
    end
    check("wait_tick_timeout", {31'd0, bus.frame_tick}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input int exp_lo, input logic [31:0] exp_segs);
    for (int k = 0; k < 4; k++) begin
      check({tag, "_lo"}, lo_cnt[k], exp_lo);
      if (exp_lo > 0) check({tag, "_seg"}, {24'd0, seg_seen[k]}, {24'd0, exp_segs[8*k +: 8]});
    end
    check({tag, "_dark"}, dark_cnt, FRAME - 4 * exp_lo);
    check({tag, "_dark_seg"}, dark_seg_bad, 0);
  endtask

  initial begin
    bus.digits_in  = {5'h08, 5'h1A, 5'h01, 5'h00};
    bus.brightness = 2'd3;
    fork
      compare_loop();
    join_none

    // Reset and first frame_tick
    repeat (4) @(negedge mclk);
    check("rst_anode", {28'd0, bus.anode_sel}, 32'hF);
    check("rst_seg", {24'd0, bus.segments_out}, 32'hFF);
    check("rst_tick", {31'd0, bus.frame_tick}, 32'd0);
    #1 rst_N = 1'b1;
    @(negedge mclk);
    check("first_tick", {31'd0, bus.frame_tick}, 32'd1);

    // Scan and decode at brightness 3
    measure();
    check_frame("scan_b3", 48, {8'h01, 8'h10, 8'h9F, 8'h03});

    // Brightness 1
    #1 bus.brightness = 2'd1;
    wait_tick();
    measure();
    check_frame("scan_b1", 16, {8'h01, 8'h10, 8'h9F, 8'h03});

    // Brightness 0
    #1 bus.brightness = 2'd0;
    wait_tick();
    measure();
    check_frame("scan_b0", 0, 32'd0);

    // Tear-free capture: change digits at cycle 100 of a frame
    #1 bus.brightness = 2'd3;
    wait_tick();
    repeat (100) @(negedge mclk);
    #1 bus.digits_in = {5'h12, 5'h0B, 5'h07, 5'h19};
    repeat (2) @(negedge mclk);
    check("tear_anode", {28'd0, bus.anode_sel}, 32'hD);
    check("tear_seg_old", {24'd0, bus.segments_out}, 32'h9F);
    wait_tick();
    check("tear_anode_new", {28'd0, bus.anode_sel}, 32'hE);
    check("tear_seg_new", {24'd0, bus.segments_out}, 32'h08);

    // Async reset at cycle 37 of a frame
    wait_tick();
    repeat (37) @(negedge mclk);
    #3 rst_N = 1'b0;
    #1;
    check("async_rst_anode", {28'd0, bus.anode_sel}, 32'hF);
    check("async_rst_seg", {24'd0, bus.segments_out}, 32'hFF);
    check("async_rst_tick", {31'd0, bus.frame_tick}, 32'd0);
    repeat (3) @(negedge mclk);
    #1 rst_N = 1'b1;
    wait_tick();
    check("restart_anode", {28'd0, bus.anode_sel}, 32'hE);
    check("restart_seg", {24'd0, bus.segments_out}, 32'h08);

`ifdef SEVEN_SEG_LZB_EN
    // Leading-zero blanking
    #1 bus.digits_in = {5'h00, 5'h00, 5'h03, 5'h00};
    wait_tick();
    measure();
    check_frame("lzb", 48, {8'hFF, 8'hFF, 8'h0D, 8'h03});
`endif

    repeat (2) @(negedge mclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
